// File: rtl/pixel_fetch_pkg.sv
// Shared definitions for the framebuffer prefetcher: frame geometry defaults,
// pixel format with colour-field accessors, and the fetch FSM state encoding.
package pixel_fetch_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W        = 12;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] pix_red(input pixel_t p);
        return p[11:8];
    endfunction

    function automatic logic [3:0] pix_green(input pixel_t p);
        return p[7:4];
    endfunction

    function automatic logic [3:0] pix_blue(input pixel_t p);
        return p[3:0];
    endfunction

endpackage

// File: rtl/pixel_fetch_fifo.sv
// Synchronous show-ahead FIFO; the head is registered and reads 0 when empty.
module pixel_fifo
    import pixel_fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PIX_W-1:0]         din,
    output logic [PIX_W-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    pixel_t         mem_r [DEPTH];
    logic [AW-1:0]  rd_ptr_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [LW-1:0]  level_r;
    pixel_t         head_r;

    logic           pop_ok_s;
    logic           push_ok_s;
    logic [AW-1:0]  rd_next_s;
    logic [LW-1:0]  remain_s;
    pixel_t         head_next_s;

    // Accept a push when full only if the head leaves in the same cycle.
    always_comb begin
        pop_ok_s  = pop && (level_r != {LW{1'b0}});
        push_ok_s = push && ((level_r != LW'(DEPTH)) || pop_ok_s);
        rd_next_s = rd_ptr_r + AW'(pop_ok_s);
        remain_s  = level_r - LW'(pop_ok_s);
        if (flush) begin
            head_next_s = {PIX_W{1'b0}};
        end else if (remain_s != {LW{1'b0}}) begin
            head_next_s = mem_r[rd_next_s];
        end else if (push_ok_s) begin
            head_next_s = din;
        end else begin
            head_next_s = {PIX_W{1'b0}};
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            head_r   <= {PIX_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            head_r   <= {PIX_W{1'b0}};
        end else begin
            rd_ptr_r <= rd_next_s;
            wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
            level_r  <= remain_s + LW'(push_ok_s);
            head_r   <= head_next_s;
        end
    end

    assign head  = head_r;
    assign level = level_r;

endmodule

// File: rtl/pixel_fetch.sv
// Framebuffer read prefetcher: walks one frame of addresses over a single
// outstanding request port and feeds the colour stage from a show-ahead FIFO.
module pixel_fetch
    import pixel_fetch_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    h_active,
    input  logic                    v_active,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [PIX_W-1:0]        mem_data,
    output logic [PIX_W-1:0]        current_pixel,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    underrun
);
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  addr_r;
    logic               v_d_r;
    logic               underrun_r;

    logic               frame_end_s;
    logic               flush_s;
    logic               ack_ok_s;
    logic               pop_s;

    assign frame_end_s = v_d_r && !v_active;
    assign pop_s       = h_active && v_active;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FLUSH;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; frame end overrides everything.
    always_comb begin
        state_s = state_r;
        if (frame_end_s) begin
            state_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_FLUSH: state_s = ST_FETCH;
                ST_FETCH: begin
                    if (ack_ok_s && (addr_r == ADDR_W'(TOTAL - 1))) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_DONE:  state_s = ST_DONE;
                default:  state_s = ST_FLUSH;
            endcase
        end
    end

    // FSM outputs; an ack landing on the frame-end cycle is dropped.
    always_comb begin
        mem_req = 1'b0;
        case (state_r)
            ST_FETCH: mem_req = (fifo_level != LW'(DEPTH));
            ST_FLUSH: mem_req = 1'b0;
            ST_DONE:  mem_req = 1'b0;
            default:  mem_req = 1'b0;
        endcase
        flush_s  = frame_end_s || (state_r == ST_FLUSH);
        ack_ok_s = mem_ack && mem_req && !frame_end_s;
    end

    // Address counter, frame-end edge detector and sticky underrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= {ADDR_W{1'b0}};
            v_d_r      <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            v_d_r <= v_active;
            if (flush_s) begin
                addr_r <= {ADDR_W{1'b0}};
            end else if (ack_ok_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                addr_r <= addr_r;
            end
            if (pop_s && (fifo_level == {LW{1'b0}})) begin
                underrun_r <= 1'b1;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (ack_ok_s),
        .pop   (pop_s),
        .din   (mem_data),
        .head  (current_pixel),
        .level (fifo_level)
    );

    assign mem_addr = addr_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_pixel_fetch;
    localparam int H      = 8;
    localparam int V      = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 7;
    localparam int TOTAL  = H * V;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              h_active = 1'b0;
    logic              v_active = 1'b0;
    logic              mem_ack = 1'b0;
    logic [11:0]       mem_data = 12'h000;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       current_pixel;
    logic [LW-1:0]     fifo_level;
    logic              underrun;

    int checks = 0;
    int failures = 0;

    pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .h_active(h_active), .v_active(v_active),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .current_pixel(current_pixel), .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Behavioural model: the FIFO is a queue, "done" is simply addr == TOTAL.
    logic [11:0] mq[$];
    int          m_addr;
    bit          m_flush;
    bit          m_vd;
    bit          m_under;

    function automatic bit m_req();
        return !m_flush && (m_addr < TOTAL) && (mq.size() < DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr  = 0;
        m_flush = 1'b1;
        m_vd    = 1'b0;
        m_under = 1'b0;
    endtask

    // Applies the rules for the coming clock edge using the current inputs.
    task automatic model_update();
        bit fe, pop, acc;
        fe  = m_vd && !v_active;
        pop = h_active && v_active;
        acc = mem_ack && m_req() && !fe;
        if (pop && mq.size() == 0) m_under = 1'b1;
        if (fe || m_flush) begin
            mq.delete();
            m_addr = 0;
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(mem_data);
                m_addr++;
            end
        end
        m_flush = fe;
        m_vd    = v_active;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("req",   {31'd0, mem_req}, {31'd0, m_req()});
                chk("addr",  32'(mem_addr), 32'(m_addr));
                chk("pixel", 32'(current_pixel), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
                chk("level", 32'(fifo_level), 32'(mq.size()));
                chk("underrun", {31'd0, underrun}, {31'd0, m_under});
            end
        end
    end

    initial begin
        bit found;
        int cyc;
        int run_len;
        int pop_pct;

        model_reset();
        #2;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_pixel", 32'(current_pixel), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        do_reset();

        // Fill with data = address, no popping.
        mem_ack = 1'b1;
        for (int i = 0; i < 17; i++) begin
            mem_data = 12'(mem_addr);
            step();
        end
        chk("t1_level", 32'(fifo_level), 32'd16);
        chk("t1_req", {31'd0, mem_req}, 32'd0);
        chk("t1_addr", 32'(mem_addr), 32'd16);

        // Pop from full: head streams 0,1,2; level settles one below full.
        h_active = 1'b1;
        v_active = 1'b1;
        chk("t2_pix0", 32'(current_pixel), 32'h000);
        mem_data = 12'(mem_addr);
        step();
        chk("t2_pix1", 32'(current_pixel), 32'h001);
        mem_data = 12'(mem_addr);
        step();
        chk("t2_pix2", 32'(current_pixel), 32'h002);
        chk("t2_level", 32'(fifo_level), 32'd15);

        // Starve the FIFO while popping.
        mem_ack = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("t3_pixel", 32'(current_pixel), 32'h000);
        chk("t3_level", 32'(fifo_level), 32'd0);
        chk("t3_underrun", {31'd0, underrun}, 32'd1);
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_data = 12'(mem_addr);
            step();
        end
        chk("t3_sticky", {31'd0, underrun}, 32'd1);

        // Frame end coinciding with the ack of address 37.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mem_req && mem_addr == 7'd37) begin
                found = 1'b1;
            end else begin
                mem_data = 12'(mem_addr);
                step();
            end
        end
        chk("t4_reach37", {31'd0, found}, 32'd1);
        mem_data = 12'(mem_addr);
        v_active = 1'b0;
        h_active = 1'b0;
        step();
        step();
        chk("t4_level", 32'(fifo_level), 32'd0);
        chk("t4_addr", 32'(mem_addr), 32'd0);
        chk("t4_req", {31'd0, mem_req}, 32'd1);
        mem_data = 12'(mem_addr);
        step();
        chk("t4_head0", 32'(current_pixel), 32'h000);
        chk("t4_level1", 32'(fifo_level), 32'd1);

        // Whole frame fetched: request stays low, FIFO drains.
        do_reset();
        v_active = 1'b1;
        h_active = 1'b1;
        for (int i = 0; i < 100; i++) begin
            mem_data = 12'($urandom);
            step();
        end
        chk("t5_req", {31'd0, mem_req}, 32'd0);
        chk("t5_addr", 32'(mem_addr), 32'(TOTAL));
        for (int i = 0; i < 20; i++) step();
        chk("t5_level", 32'(fifo_level), 32'd0);
        chk("t5_req_hold", {31'd0, mem_req}, 32'd0);

        // Asynchronous reset with a request pending and underrun set.
        do_reset();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6_pre_req", {31'd0, mem_req}, 32'd1);
        chk("t6_pre_underrun", {31'd0, underrun}, 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_req", {31'd0, mem_req}, 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_pixel", 32'(current_pixel), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_underrun", {31'd0, underrun}, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic with frame ends at random points.
        cyc = 0;
        while (cyc < 4000) begin
            run_len  = $urandom_range(20, 150);
            v_active = 1'b1;
            case ($urandom_range(0, 3))
                0: pop_pct = 0;
                1: pop_pct = 50;
                2: pop_pct = 90;
                default: pop_pct = 100;
            endcase
            for (int i = 0; i < run_len; i++) begin
                h_active = ($urandom_range(0, 99) < pop_pct);
                mem_ack  = ($urandom_range(0, 99) < 70);
                mem_data = 12'($urandom);
                step();
            end
            v_active = 1'b0;
            run_len  = $urandom_range(2, 10);
            for (int i = 0; i < run_len; i++) begin
                h_active = $urandom_range(0, 1) == 1;
                mem_ack  = ($urandom_range(0, 99) < 70);
                mem_data = 12'($urandom);
                step();
            end
            cyc += 160;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
